// File: rtl/tft_pkg.sv
// Shared TFT definitions: controller command bytes, arbiter state encoding and
// the byte payload carried from a client to the serializer.
package tft_pkg;

  localparam logic [7:0] TFT_CMD_CASET = 8'h2A;
  localparam logic [7:0] TFT_CMD_PASET = 8'h2B;
  localparam logic [7:0] TFT_CMD_RAMWR = 8'h2C;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN   = 2'd1,
    ST_DRAIN = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic       dc;
    logic [7:0] data;
  } tft_byte_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Ports:
//   req      in  N       request vector
//   last     in  IW      index of the previous winner
//   last_vld in  1       0 = no previous winner, search starts at index 0
//   gnt      out N       one-hot winner, 0 when no request
module rr_pick #(
  parameter int unsigned N  = 3,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  input  logic          last_vld,
  output logic [N-1:0]  gnt
);

  // Scan N positions starting one past the previous winner, first hit wins.
  always_comb begin
    int unsigned start_i;
    int unsigned idx_i;
    logic        found;
    gnt     = '0;
    found   = 1'b0;
    start_i = last_vld ? ((32'(last) + 32'd1) % N) : 32'd0;
    for (int unsigned k = 0; k < N; k++) begin
      idx_i = (start_i + k) % N;
      if (!found && req[IW'(idx_i)]) begin
        gnt[IW'(idx_i)] = 1'b1;
        found           = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tft_arbiter.sv
// Shares one byte-wide TFT serializer link between N_REQ drawing clients.
// A client owns the link for a whole window transaction; ownership only
// changes after the link has drained.
// Ports:
//   clk, rst          clock, synchronous active-low reset
//   req / grant       per-client ownership request / one-hot owner
//   cl_transmit/dc/data  per-client byte strobe, dc bit, byte (client i at [8i+7:8i])
//   cl_busy           per-client busy, combinational view of the link
//   tft_busy          serializer busy
//   tft_transmit/dc/data  registered byte strobe and payload to serializer
//   err_proto         sticky: strobe while that client's cl_busy was high
//   err_timeout       sticky: owner revoked after TIMEOUT idle cycles
module tft_arbiter
  import tft_pkg::*;
#(
  parameter int unsigned N_REQ   = 3,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  output logic [N_REQ-1:0]   grant,
  input  logic [N_REQ-1:0]   cl_transmit,
  input  logic [N_REQ-1:0]   cl_dc,
  input  logic [8*N_REQ-1:0] cl_data,
  output logic [N_REQ-1:0]   cl_busy,
  input  logic               tft_busy,
  output logic               tft_transmit,
  output logic               tft_dc,
  output logic [7:0]         tft_data,
  output logic               err_proto,
  output logic               err_timeout
);

  localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  arb_state_e       state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [IW-1:0]    own_q, own_d;
  logic [IW-1:0]    rr_q, rr_d;
  logic             rr_vld_q, rr_vld_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             xmit_q, xmit_d;
  tft_byte_t        byte_q, byte_d;
  logic             err_proto_q, err_proto_d;
  logic             err_timeout_q, err_timeout_d;

  logic [N_REQ-1:0] pick;
  logic [IW-1:0]    pick_idx;
  logic             own_busy;
  logic             accept;
  logic             tmo_hit;
  logic             sel_dc;
  logic [7:0]       sel_data;

  rr_pick #(.N(N_REQ), .IW(IW)) u_rr_pick (
    .req      (req),
    .last     (rr_q),
    .last_vld (rr_vld_q),
    .gnt      (pick)
  );

  // One-hot winner to index.
  always_comb begin
    pick_idx = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (pick[i]) pick_idx = IW'(i);
    end
  end

  // Owner's byte mux.
  always_comb begin
    sel_dc   = 1'b0;
    sel_data = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (own_q == IW'(i)) begin
        sel_dc   = cl_dc[i];
        sel_data = cl_data[8*i +: 8];
      end
    end
  end

  // Owner sees the raw link; everyone else is held off.
  assign own_busy = tft_busy | xmit_q;

  always_comb begin
    cl_busy = '1;
    if (state_q == ST_OWN) cl_busy[own_q] = own_busy;
  end

  assign accept  = (state_q == ST_OWN) & cl_transmit[own_q] & ~own_busy;
  // A byte in the final idle cycle resets the count instead of revoking.
  assign tmo_hit = (TIMEOUT != 0) && (state_q == ST_OWN) &&
                   (cnt_q == CW'(TIMEOUT - 1)) && !accept;

  // Next-state and output logic.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    own_d         = own_q;
    rr_d          = rr_q;
    rr_vld_d      = rr_vld_q;
    cnt_d         = cnt_q;
    xmit_d        = 1'b0;
    byte_d        = byte_q;
    err_proto_d   = err_proto_q | (|(cl_transmit & cl_busy));
    err_timeout_d = err_timeout_q;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (|req) begin
          grant_d = pick;
          own_d   = pick_idx;
          state_d = ST_OWN;
        end
      end
      ST_OWN: begin
        if (accept) begin
          xmit_d      = 1'b1;
          byte_d.dc   = sel_dc;
          byte_d.data = sel_data;
          cnt_d       = '0;
        end else if (TIMEOUT != 0) begin
          cnt_d = cnt_q + CW'(1);
        end
        if (!req[own_q] || tmo_hit) begin
          grant_d       = '0;
          state_d       = ST_DRAIN;
          err_timeout_d = err_timeout_q | tmo_hit;
        end
      end
      ST_DRAIN: begin
        if (!tft_busy && !xmit_q) begin
          rr_d     = own_q;
          rr_vld_d = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      grant_q       <= '0;
      own_q         <= '0;
      rr_q          <= '0;
      rr_vld_q      <= 1'b0;
      cnt_q         <= '0;
      xmit_q        <= 1'b0;
      byte_q        <= '0;
      err_proto_q   <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      own_q         <= own_d;
      rr_q          <= rr_d;
      rr_vld_q      <= rr_vld_d;
      cnt_q         <= cnt_d;
      xmit_q        <= xmit_d;
      byte_q        <= byte_d;
      err_proto_q   <= err_proto_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign grant        = grant_q;
  assign tft_transmit = xmit_q;
  assign tft_dc       = byte_q.dc;
  assign tft_data     = byte_q.data;
  assign err_proto    = err_proto_q;
  assign err_timeout  = err_timeout_q;

endmodule

// File: tb/tb_tft_arbiter.sv
// Directed bench for tft_arbiter with a serializer model and a byte scoreboard.
module tb_tft_arbiter;
  import tft_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req;
  logic [2:0]  grant;
  logic [2:0]  cl_transmit;
  logic [2:0]  cl_dc;
  logic [23:0] cl_data;
  logic [2:0]  cl_busy;
  logic        tft_busy;
  logic        tft_transmit;
  logic        tft_dc;
  logic [7:0]  tft_data;
  logic        err_proto;
  logic        err_timeout;

  int tests = 0;
  int fails = 0;

  logic [8:0] sb_q[$];
  logic       prev_x = 1'b0;
  logic [2:0] ser_cnt = 3'd0;

  always #5 clk = ~clk;

  tft_arbiter #(.N_REQ(3), .TIMEOUT(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .grant        (grant),
    .cl_transmit  (cl_transmit),
    .cl_dc        (cl_dc),
    .cl_data      (cl_data),
    .cl_busy      (cl_busy),
    .tft_busy     (tft_busy),
    .tft_transmit (tft_transmit),
    .tft_dc       (tft_dc),
    .tft_data     (tft_data),
    .err_proto    (err_proto),
    .err_timeout  (err_timeout)
  );

  // Serializer: busy for 4 cycles after seeing a strobe.
  always @(posedge clk) begin
    if (tft_transmit) ser_cnt <= 3'd4;
    else if (ser_cnt != 3'd0) ser_cnt <= ser_cnt - 3'd1;
  end
  assign tft_busy = (ser_cnt != 3'd0);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every forwarded byte must match the oldest accepted strobe.
  always @(negedge clk) begin
    logic [8:0] exp;
    if (tft_transmit) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_xmit", 32'(tft_transmit), 32'd0);
      end else begin
        exp = sb_q.pop_front();
        chk("sb_byte", 32'({tft_dc, tft_data}), 32'(exp));
      end
      chk("xmit_pulse_width", 32'(prev_x), 32'd0);
    end
    prev_x = tft_transmit;
  end

  task automatic wait_grant(input logic [2:0] exp, input string tag);
    int n = 0;
    while (grant == 3'b000 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(grant), 32'(exp));
  endtask

  // Wait for cl_busy low, strobe one byte, optionally drop req in the same cycle.
  task automatic send_byte(input int idx, input logic dc, input logic [7:0] d, input logic drop);
    int n = 0;
    while (cl_busy[idx] && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (cl_busy[idx]) begin
      chk("send_wait_busy", 32'(cl_busy[idx]), 32'd0);
    end else begin
      cl_transmit[idx]   = 1'b1;
      cl_dc[idx]         = dc;
      cl_data[8*idx +: 8] = d;
      if (drop) req[idx] = 1'b0;
      sb_q.push_back({dc, d});
      @(negedge clk);
      cl_transmit[idx] = 1'b0;
    end
  endtask

  task automatic settle(input string tag);
    int n = 0;
    while ((sb_q.size() != 0 || tft_busy || tft_transmit || grant != 3'b000) && n < 80) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'({tft_busy, tft_transmit, grant}), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [7:0] seq [11];
    logic [2:0] exp_g [4];
    int         own [4];
    int         n;

    seq = '{TFT_CMD_CASET, 8'h00, 8'h05, 8'h00, 8'h1A,
            TFT_CMD_PASET, 8'h00, 8'h05, 8'h00, 8'h1A, TFT_CMD_RAMWR};
    exp_g = '{3'b001, 3'b010, 3'b100, 3'b001};
    own   = '{0, 1, 2, 0};

    rst = 1'b0; req = '0; cl_transmit = '0; cl_dc = '0; cl_data = '0;

    // Reset values.
    repeat (2) @(negedge clk);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_xmit", 32'(tft_transmit), 32'd0);
    chk("rst_cl_busy", 32'(cl_busy), 32'h7);
    chk("rst_errs", 32'({err_proto, err_timeout}), 32'd0);
    rst = 1'b1;

    // Single owner window transaction.
    req[1] = 1'b1;
    wait_grant(3'b010, "single_grant");
    chk("single_others_busy", 32'({cl_busy[2], cl_busy[0]}), 32'h3);
    for (int i = 0; i < 11; i++) begin
      send_byte(1, !(seq[i] == TFT_CMD_CASET || seq[i] == TFT_CMD_PASET ||
                     seq[i] == TFT_CMD_RAMWR), seq[i], i == 10);
      if (i == 5) chk("single_grant_held", 32'(grant), 32'h2);
    end
    settle("single_release");

    // Non-owner strobe is dropped and flagged.
    req = 3'b001;
    wait_grant(3'b001, "np_grant");
    cl_transmit[2] = 1'b1; cl_dc[2] = 1'b1; cl_data[23:16] = 8'hFF;
    @(negedge clk);
    cl_transmit[2] = 1'b0;
    repeat (3) @(negedge clk);
    chk("np_err_proto", 32'(err_proto), 32'd1);
    chk("np_owner_kept", 32'(grant), 32'h1);
    chk("np_err_timeout", 32'(err_timeout), 32'd0);
    send_byte(0, 1'b0, TFT_CMD_RAMWR, 1'b1);
    settle("np_release");
    chk("np_err_sticky", 32'(err_proto), 32'd1);

    // Reset clears sticky errors; contention starts straight out of reset.
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("err_cleared", 32'({err_proto, err_timeout}), 32'd0);
    req = 3'b111;
    for (int k = 0; k < 4; k++) begin
      wait_grant(exp_g[k], "cont_grant");
      send_byte(own[k], 1'b1, 8'h10 + 8'(k), 1'b1);
      chk("cont_gap", 32'(grant), 32'd0);
      @(negedge clk);
      chk("cont_gap_busy", 32'({tft_busy, grant}), 32'h8);
      if (k < 3) req[own[k]] = 1'b1;
    end

    // Timeout: client 1 holds req silently while client 2 waits.
    wait_grant(3'b010, "tmo_grant");
    n = 0;
    while (grant == 3'b010 && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("tmo_cycles", 32'(n), 32'd16);
    chk("tmo_err", 32'(err_timeout), 32'd1);
    wait_grant(3'b100, "tmo_next_owner");

    // Reset while a byte is on the link.
    send_byte(2, 1'b1, 8'h55, 1'b0);
    chk("mr_xmit_high", 32'(tft_transmit), 32'd1);
    rst = 1'b0;
    req = 3'b000;
    @(negedge clk);
    chk("mr_xmit_low", 32'(tft_transmit), 32'd0);
    chk("mr_grant_low", 32'(grant), 32'd0);
    chk("mr_err_timeout", 32'(err_timeout), 32'd0);
    rst = 1'b1;
    req = 3'b100;
    wait_grant(3'b100, "mr_regrant");
    send_byte(2, 1'b0, TFT_CMD_CASET, 1'b1);
    settle("mr_release");
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
